serial_neg_array: RTL

Parametrised multi-channel serial two's-complement negator for LSB-first bit streams. It generalises the single-channel complement FSM in four ways: NCH lanes run in lockstep, word framing covers W bits, each word selects pass or negate, and an optional overflow flag reports negation of the most negative value. It sits between the serial deserialiser front end and the downstream serial accumulators.

---
 rtl/serial_neg_pkg.sv | 21 ++
 rtl/serial_neg_lane.sv | 53 +++++
 rtl/serial_neg_array.sv | 67 ++++++
 3 files changed

// File: rtl/serial_neg_pkg.sv
// Shared types for the multi-lane serial two's-complement negator.
// The overflow helper is only referenced when SERIAL_NEG_OVF_EN is defined.
package serial_neg_pkg;

  typedef enum logic {
    MODE_PASS = 1'b0,
    MODE_NEG  = 1'b1
  } mode_e;

  typedef enum logic {
    ST_COPY   = 1'b0,
    ST_INVERT = 1'b1
  } lane_state_e;

  // Negating 100...0 reproduces the input; seen as COPY state with a 1 on the MSB.
  function automatic logic ovf_cond(input mode_e mode, input lane_state_e st,
                                    input logic bit_in, input logic last_bit);
    return (mode == MODE_NEG) && (st == ST_COPY) && bit_in && last_bit;
  endfunction

endpackage

// File: rtl/serial_neg_lane.sv
// One lane of the serial negator: latched mode, COPY/INVERT state, combinational out/ovf.
// Overflow detection is built only when SERIAL_NEG_OVF_EN is defined.
module serial_neg_lane
  import serial_neg_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic first_bit,
  input  logic last_bit,
  input  logic mode_in,
  input  logic bit_in,
  output logic out_bit,
  output logic ovf
);

  lane_state_e state, state_next, eff_state;
  mode_e       mode_q, eff_mode;

  always_comb begin
    eff_state  = first_bit ? ST_COPY : state;
    eff_mode   = first_bit ? mode_e'(mode_in) : mode_q;
    out_bit    = bit_in;
    state_next = state;
    if (eff_mode == MODE_NEG && eff_state == ST_INVERT) out_bit = ~bit_in;
    if (valid) begin
      // Returning to COPY after the last bit is invisible (idx 0 forces COPY) but keeps state tidy.
      if (last_bit)
        state_next = ST_COPY;
      else if (eff_mode == MODE_NEG && (eff_state == ST_INVERT || bit_in))
        state_next = ST_INVERT;
      else
        state_next = ST_COPY;
    end
  end

`ifdef SERIAL_NEG_OVF_EN
  always_comb ovf = ovf_cond(eff_mode, eff_state, bit_in, last_bit);
`else
  always_comb ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_COPY;
      mode_q <= MODE_PASS;
    end else begin
      state <= state_next;
      if (valid && first_bit) mode_q <= eff_mode;
    end
  end

endmodule

// File: rtl/serial_neg_array.sv
// NCH lockstep LSB-first serial two's-complement negators sharing one W-bit word framer.
// out_ovf is driven only when SERIAL_NEG_OVF_EN is defined; otherwise it stays 0.
module serial_neg_array
  import serial_neg_pkg::*;
#(
  parameter int W   = 8,
  parameter int NCH = 4,
  parameter int CW  = $clog2(W)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic           in_sync,
  input  logic [NCH-1:0] in_mode,
  input  logic [NCH-1:0] in_bits,
  output logic           out_valid,
  output logic [NCH-1:0] out_bits,
  output logic           out_last,
  output logic [NCH-1:0] out_ovf
);

  logic [CW-1:0]  idx, idx_next, eff_idx;
  logic           first_bit, last_bit;
  logic [NCH-1:0] lane_out, lane_ovf;

  always_comb begin
    eff_idx   = in_sync ? '0 : idx;
    first_bit = (eff_idx == '0);
    last_bit  = (eff_idx == CW'(W - 1));
    idx_next  = idx;
    if (in_valid) idx_next = last_bit ? '0 : eff_idx + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) idx <= '0;
    else       idx <= idx_next;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    serial_neg_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .valid    (in_valid),
      .first_bit(first_bit),
      .last_bit (last_bit),
      .mode_in  (in_mode[i]),
      .bit_in   (in_bits[i]),
      .out_bit  (lane_out[i]),
      .ovf      (lane_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_last  <= 1'b0;
      out_ovf   <= '0;
    end else begin
      out_valid <= in_valid;
      out_bits  <= in_valid ? lane_out : '0;
      out_last  <= in_valid && last_bit;
      out_ovf   <= (in_valid && last_bit) ? lane_ovf : '0;
    end
  end

endmodule
